// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 LCD write controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_INIT  = 3'd1,
        ST_SETUP = 3'd2,
        ST_ENH   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_WAIT  = 3'd5,
        ST_IDLE  = 3'd6
    } lcd_state_e;

    localparam int LCD_ON_BIT  = 31;
    localparam int LCD_REQ_BIT = 10;
    localparam int LCD_RS_BIT  = 9;

    localparam int LCD_INIT_LEN = 4;
    // 8-bit/2-line, display on, clear, entry mode increment
    localparam logic [7:0] LCD_INIT_ROM [LCD_INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME     = 8'h02;
    localparam logic [7:0] LCD_CMD_HOME_ALT = 8'h03;

    // Clear and return-home need the long post-write wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] dat);
        return !rs && (dat >= LCD_CMD_CLEAR) && (dat <= LCD_CMD_HOME_ALT);
    endfunction

    function automatic int unsigned phase_len(input int unsigned n);
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by all timed phases; done while the count reads zero.
// Load takes effect on the next edge; the count holds at zero once reached.
module lcd_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Turns toggle-handshake writes of the io_lcd word into timed HD44780 8-bit write cycles.
// One request accepted per IDLE cycle; busy_o/ack_o let software poll. LCD_INIT_EN adds the power-on init ROM.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned PWRUP_CYC    = 750000,
    parameter int unsigned SETUP_CYC    = 4,
    parameter int unsigned EN_CYC       = 12,
    parameter int unsigned HOLD_CYC     = 4,
    parameter int unsigned CMD_WAIT_CYC = 2000,
    parameter int unsigned CLR_WAIT_CYC = 80000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] io_lcd_i,
    output logic [7:0]  lcd_data_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic        lcd_on_o,
    output logic        lcd_blon_o,
    output logic        busy_o,
    output logic        ack_o
);

    localparam int unsigned PWRUP_LEN = phase_len(PWRUP_CYC);
    localparam int unsigned SETUP_LEN = phase_len(SETUP_CYC);
    localparam int unsigned EN_LEN    = phase_len(EN_CYC);
    localparam int unsigned HOLD_LEN  = phase_len(HOLD_CYC);
    localparam int unsigned CMD_LEN   = phase_len(CMD_WAIT_CYC);
    localparam int unsigned CLR_LEN   = phase_len(CLR_WAIT_CYC);

    localparam int unsigned MAX_A   = (PWRUP_LEN > SETUP_LEN) ? PWRUP_LEN : SETUP_LEN;
    localparam int unsigned MAX_B   = (EN_LEN > HOLD_LEN) ? EN_LEN : HOLD_LEN;
    localparam int unsigned MAX_C   = (CMD_LEN > CLR_LEN) ? CMD_LEN : CLR_LEN;
    localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_LEN = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int          CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_LEN - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_LEN - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_LEN - 1);
    localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_LEN - 1);
    localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_LEN - 1);
    // The counter comes out of reset at 0, so the first PWRUP cycle itself arms it
    localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'((PWRUP_LEN > 1) ? PWRUP_LEN - 2 : 0);

`ifdef LCD_INIT_EN
    localparam lcd_state_e PWRUP_NEXT = ST_INIT;
`else
    localparam lcd_state_e PWRUP_NEXT = ST_IDLE;
`endif

    lcd_state_e       state, state_nxt;
    logic             armed;
    logic             ack;
    logic             rs_q;
    logic [7:0]       data_q;
    logic             en_q;
    logic             on_q;
    logic             pending;
    logic             accept;
    logic             rom_load;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;
    logic             unused_bits;

`ifdef LCD_INIT_EN
    logic [2:0]       rom_idx;
    logic             in_init;
    logic             rom_end;

    assign rom_end = (rom_idx == 3'(LCD_INIT_LEN));
`endif

    assign pending     = io_lcd_i[LCD_REQ_BIT] ^ ack;
    assign unused_bits = ^{io_lcd_i[30:11], io_lcd_i[8]};

    lcd_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .load    (tmr_load),
        .load_val(tmr_val),
        .done    (tmr_done)
    );

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        accept    = 1'b0;
        rom_load  = 1'b0;
        case (state)
            ST_PWRUP: begin
                if (!armed) begin
                    if (PWRUP_LEN == 1) begin
                        state_nxt = PWRUP_NEXT;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = PWRUP_LD;
                    end
                end else if (tmr_done) begin
                    state_nxt = PWRUP_NEXT;
                end
            end
`ifdef LCD_INIT_EN
            ST_INIT: begin
                if (rom_end) begin
                    state_nxt = ST_IDLE;
                end else begin
                    rom_load  = 1'b1;
                    state_nxt = ST_SETUP;
                    tmr_load  = 1'b1;
                    tmr_val   = SETUP_LD;
                end
            end
`endif
            ST_SETUP: begin
                if (tmr_done) begin
                    state_nxt = ST_ENH;
                    tmr_load  = 1'b1;
                    tmr_val   = EN_LD;
                end
            end
            ST_ENH: begin
                if (tmr_done) begin
                    state_nxt = ST_HOLD;
                    tmr_load  = 1'b1;
                    tmr_val   = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    state_nxt = ST_WAIT;
                    tmr_load  = 1'b1;
                    tmr_val   = is_long_cmd(rs_q, data_q) ? CLR_LD : CMD_LD;
                end
            end
            ST_WAIT: begin
                if (tmr_done) begin
`ifdef LCD_INIT_EN
                    state_nxt = in_init ? ST_INIT : ST_IDLE;
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
            ST_IDLE: begin
                if (pending) begin
                    accept    = 1'b1;
                    state_nxt = ST_SETUP;
                    tmr_load  = 1'b1;
                    tmr_val   = SETUP_LD;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= ST_PWRUP;
            armed  <= 1'b0;
            ack    <= 1'b0;
            rs_q   <= 1'b0;
            data_q <= 8'h00;
            en_q   <= 1'b0;
            on_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            en_q  <= (state_nxt == ST_ENH);
            on_q  <= io_lcd_i[LCD_ON_BIT];
            if (accept) begin
                rs_q   <= io_lcd_i[LCD_RS_BIT];
                data_q <= io_lcd_i[7:0];
                ack    <= io_lcd_i[LCD_REQ_BIT];
            end
`ifdef LCD_INIT_EN
            if (rom_load) begin
                rs_q   <= 1'b0;
                data_q <= LCD_INIT_ROM[rom_idx[1:0]];
            end
`endif
        end
    end

`ifdef LCD_INIT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rom_idx <= 3'd0;
            in_init <= 1'b1;
        end else begin
            if (rom_load) begin
                rom_idx <= rom_idx + 3'd1;
            end
            if (state == ST_INIT && rom_end) begin
                in_init <= 1'b0;
            end
        end
    end
`endif

    assign lcd_data_o = data_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_rw_o   = 1'b0;
    assign lcd_en_o   = en_q;
    assign lcd_on_o   = on_q;
    assign lcd_blon_o = on_q;
    assign busy_o     = (state != ST_IDLE) || pending;
    assign ack_o      = ack;

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Peripheral-side responder for the CPU's memory-mapped LCD output word (io_lcd).
- Sits outside the pipeline core. It takes the 32-bit LCD register value and turns each new write request into a timed HD44780 8-bit write cycle on the character LCD pins.
- It optionally runs the power-on initialisation sequence.
- It exposes busy/acknowledge status so software can later poll it through an input map.

Parameters:
- PWRUP_CYC, 750000, cycles waited after reset before the first bus cycle (15 ms @ 50 MHz).
- SETUP_CYC, 4, RS/DATA setup before EN rises.
- EN_CYC, 12, EN high width.
- HOLD_CYC, 4, RS/DATA hold after EN falls.
- CMD_WAIT_CYC, 2000, post-write wait for normal commands and data (40 us).
- CLR_WAIT_CYC, 80000, post-write wait for clear/home commands (1.6 ms).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- io_lcd_i  in  32  LCD register from the core: [31] ON, [10] REQ toggle, [9] RS, [7:0] DATA; other bits ignored
- lcd_data_o  out  8  LCD data bus
- lcd_rs_o  out  1  register select
- lcd_rw_o  out  1  read/write; always 0 (write only)
- lcd_en_o  out  1  enable strobe
- lcd_on_o  out  1  LCD power
- lcd_blon_o  out  1  backlight, equal to lcd_on_o
- busy_o  out  1  1 while a transfer, init or power-up wait is in progress, or a request is pending
- ack_o  out  1  copy of the last accepted REQ value

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: all outputs 0, except busy_o=1. The state is PWRUP, the counter is 0 and ack_o is 0.
- lcd_on_o and lcd_blon_o are a registered copy of io_lcd_i[31], with 1-cycle latency, independent of the FSM. They are forced to 0 during reset.
- Handshake (toggle protocol):
  - A request is pending when io_lcd_i[10] differs from ack_o.
  - In IDLE, a pending request is accepted in one cycle: RS and DATA are latched and ack_o is set to io_lcd_i[10]. The FSM goes to SETUP.
  - Changes to io_lcd_i while busy do not affect the transfer in progress.
  - A request pending at the end of a transfer is accepted on the first IDLE cycle.
  - Two toggles during one busy period cancel out, and no request is raised. Software must poll ack_o.
- States:
  - PWRUP: count PWRUP_CYC cycles. Then go to INIT if LCD_INIT_EN is defined, else IDLE.
  - INIT: load the next init-ROM entry (RS=0) and go to SETUP. After the last entry, go to IDLE.
  - SETUP: drive lcd_data_o/lcd_rs_o for SETUP_CYC cycles, with EN=0.
  - ENH: EN=1 for EN_CYC cycles.
  - HOLD: EN=0 for HOLD_CYC cycles, with the bus held.
  - WAIT: wait CLR_WAIT_CYC cycles if RS=0 and DATA is in 0x01..0x03, else CMD_WAIT_CYC. Then return to INIT (during init) or IDLE.
  - IDLE: busy_o = pending request.
- Counter: one down-counter, wide enough for the largest parameter. It is loaded with N-1 on state entry, and the state exits on the cycle the counter reads 0. Each phase therefore lasts exactly N cycles. Any parameter with value 0 is treated as 1.
- lcd_data_o/lcd_rs_o keep the last value in IDLE. lcd_rw_o is constant 0.
- Requests arriving during PWRUP or INIT stay pending and are served after init.
- Reset asserted mid-transfer: immediate return to reset values, with EN low in the same cycle (asynchronous). Everything restarts from PWRUP.

Optional Feature:
- Macro: LCD_INIT_EN.
- Defined: after PWRUP, send the 4-entry ROM 0x38 (8-bit, 2 lines), 0x0C (display on), 0x01 (clear, long wait), 0x06 (entry mode), then go to IDLE.
- Undefined: PWRUP goes directly to IDLE. The ROM and INIT state are not built, and software must initialise the LCD.

Decomposition:
- Package lcd_pkg holds:
  - the state enum lcd_state_e;
  - bit-position constants LCD_ON_BIT=31, LCD_REQ_BIT=10, LCD_RS_BIT=9;
  - the init-ROM constant array and LCD_INIT_LEN=4;
  - clear/home command codes.
- One sub-module, lcd_timer: a loadable down-counter with a done flag, shared by all timed states.

Test Plan:
Parameters for the bench: PWRUP=10, SETUP=2, EN=3, HOLD=2, CMD_WAIT=5, CLR_WAIT=20.
- Reset: rst_ni low for 3 cycles, then high -> all outputs 0 and busy_o=1. With LCD_INIT_EN undefined, busy_o falls 10 cycles after reset release.
- Init (LCD_INIT_EN defined) -> four EN pulses, each 3 cycles wide, with data 0x38, 0x0C, 0x01, 0x06. The gap after 0x01 is 20 cycles, the others 5. ack_o stays 0.
- Data write: io_lcd_i=0x8000_0641 (ON, REQ=1, RS=1, 'A') -> lcd_on_o=1 next cycle. Then RS=1 and DATA=0x41; EN rises 2 cycles after accept and stays high 3 cycles. ack_o=1; busy_o drops 12 cycles after accept.
- Request during busy: toggle REQ while in ENH -> the current transfer completes unchanged. The new transfer is accepted on the first IDLE cycle with the new DATA.
- Double toggle during busy -> no second EN pulse and ack_o unchanged.
- Reset mid-transfer: assert rst_ni during ENH -> lcd_en_o=0 in the same cycle and busy_o=1. Reset values and the PWRUP wait restart.
